// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - shared state type and run-length defaults for the memory stream controller
package mem_sys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_RD_LEN  = 25;
    localparam int DEF_WR_BASE = 200;
    localparam int DEF_WR_LEN  = 9;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - first-word-fall-through response FIFO between memory and PE array
module mem_rsp_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int FIFO_D = 4,
    localparam int AW     = $clog2(FIFO_D),
    localparam int CW     = $clog2(FIFO_D + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [FIFO_D];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_D));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push-on-full with pop is accepted.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mem_stream_ctrl.sv
// rtl/mem_stream_ctrl.sv - streams a memory block to the PE array and writes results back
module mem_stream_ctrl
    import mem_sys_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 8,
    parameter int RD_BASE = 0,
    parameter int RD_LEN  = DEF_RD_LEN,
    parameter int WR_BASE = DEF_WR_BASE,
    parameter int WR_LEN  = DEF_WR_LEN,
    parameter int FIFO_D  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic              err,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    output logic              rd_rsp_ready,
    input  logic [WIDTH-1:0]  rd_rsp_data,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [WIDTH-1:0]  flit_data,
    output logic              flit_last,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [WIDTH-1:0]  res_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);

    localparam int RCW = cnt_w(RD_LEN);
    localparam int WCW = cnt_w(WR_LEN);
    localparam int OCW = cnt_w(FIFO_D);
    localparam logic [RCW-1:0] RD_LEN_C  = RCW'(RD_LEN);
    localparam logic [RCW-1:0] RD_LAST_C = RCW'(RD_LEN - 1);
    localparam logic [WCW-1:0] WR_LEN_C  = WCW'(WR_LEN);
    localparam logic [OCW:0]   FIFO_D_C  = (OCW+1)'(FIFO_D);

    state_t             state_q, state_d;
    logic [RCW-1:0]     rd_sent_q, flits_q;
    logic [OCW-1:0]     out_q;
    logic [WCW-1:0]     res_acc_q, wr_done_q;
    logic               err_q, wr_full_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [WIDTH-1:0]   wr_data_q;

    logic               run, start_run, all_done, room;
    logic               req_fire, rsp_fire, flit_fire, res_fire, wr_fire;
    logic [OCW-1:0]     fifo_count;
    logic               fifo_full, fifo_empty;
    logic [OCW:0]       inflight;

    assign run       = (state_q == RUN);
    assign start_run = start & ~run;

    // Requests are throttled so every outstanding response has a guaranteed FIFO slot.
    assign inflight     = {1'b0, out_q} + {1'b0, fifo_count};
    assign room         = ~fifo_full & (inflight < FIFO_D_C);
    assign rd_req_valid = run & (rd_sent_q != RD_LEN_C) & room;
    assign rd_req_addr  = ADDR_W'(RD_BASE) + ADDR_W'(rd_sent_q);
    assign req_fire     = rd_req_valid & rd_req_ready;
    assign rd_rsp_ready = run & (out_q != '0);
    assign rsp_fire     = rd_rsp_valid & rd_rsp_ready;

    assign flit_valid = ~fifo_empty;
    assign flit_last  = flit_valid & (flits_q == RD_LAST_C);
    assign flit_fire  = flit_valid & flit_ready;

    assign wr_valid  = wr_full_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_fire   = wr_full_q & wr_ready;
    assign res_ready = run & (~wr_full_q | wr_ready) & (res_acc_q != WR_LEN_C);
    assign res_fire  = res_valid & res_ready;

    assign all_done = (rd_sent_q == RD_LEN_C) & (flits_q == RD_LEN_C) &
                      (wr_done_q == WR_LEN_C) & fifo_empty & ~wr_full_q;
    assign done = (state_q == DONE);
    assign err  = err_q;

    mem_rsp_fifo #(
        .WIDTH  (WIDTH),
        .FIFO_D (FIFO_D)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_run),
        .push_i      (rsp_fire),
        .push_data_i (rd_rsp_data),
        .pop_i       (flit_fire),
        .head_o      (flit_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (all_done) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_sent_q <= '0;
            flits_q   <= '0;
            out_q     <= '0;
            res_acc_q <= '0;
            wr_done_q <= '0;
            err_q     <= 1'b0;
            wr_full_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            // err survives restarts; only reset clears it.
            err_q   <= err_q | (rd_rsp_valid & (out_q == '0));
            if (start_run) begin
                rd_sent_q <= '0;
                flits_q   <= '0;
                out_q     <= '0;
                res_acc_q <= '0;
                wr_done_q <= '0;
                wr_full_q <= 1'b0;
            end else begin
                rd_sent_q <= rd_sent_q + RCW'(req_fire);
                flits_q   <= flits_q + RCW'(flit_fire);
                out_q     <= out_q + OCW'(req_fire) - OCW'(rsp_fire);
                res_acc_q <= res_acc_q + WCW'(res_fire);
                wr_done_q <= wr_done_q + WCW'(wr_fire);
                if (res_fire) begin
                    wr_full_q <= 1'b1;
                    wr_addr_q <= ADDR_W'(WR_BASE) + ADDR_W'(res_acc_q);
                    wr_data_q <= res_data;
                end else if (wr_fire) begin
                    wr_full_q <= 1'b0;
                end
            end
        end
    end

endmodule
